// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single sync_fifo with burst locking.
// The granted producer owns the FIFO write port until it ends its burst or hits MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [NUM_REQ-1:0]       gnt_onehot,
  output logic                     busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  CNT_END  = CW'(MAX_BURST - 1);

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] last_gnt_q, last_gnt_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             any_valid;
  logic [IDW-1:0]   pick_id;
  logic             accept;
  logic             burst_done;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Scan offsets from farthest to nearest so the first valid after last_gnt wins.
  always_comb begin
    any_valid = |req_valid;
    pick_id   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && (j == ((int'(last_gnt_q) + k) % NUM_REQ))) begin
          pick_id = IDW'(j);
        end
      end
    end
  end

  assign busy       = (state_q == ST_BURST);
  assign accept     = busy & sel_valid & ~fifo_full;
  assign burst_done = accept & (sel_last | (beat_cnt_q == CNT_END));

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          gnt_id_d   = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (burst_done) begin
          last_gnt_d = gnt_id_q;
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      last_gnt_q <= LAST_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && (gnt_id_q == IDW'(i))) begin
        gnt_onehot[i] = 1'b1;
        req_ready[i]  = ~fifo_full;
      end
    end
  end

  assign fifo_w_en    = accept;
  assign fifo_data_in = busy ? sel_data : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus hand-written corner sequences,
// with expected outputs queued at drive time and popped when the outputs are sampled.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  reqValid;
  logic [3:0]  reqLast;
  logic [63:0] reqData;
  logic [3:0]  reqReady;
  logic        fifoFull;
  logic        fifoWEn;
  logic [15:0] fifoDataIn;
  logic [3:0]  gntOnehot;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [63:0] data;
    logic [3:0]  eReady;
    logic        eWen;
    logic [15:0] eData;
    logic [3:0]  eGnt;
    logic        eBusy;
  } vec_t;

  typedef struct {
    logic [3:0]  ready;
    logic        wen;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        busy;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (reqValid),
    .req_last     (reqLast),
    .req_data     (reqData),
    .req_ready    (reqReady),
    .fifo_full    (fifoFull),
    .fifo_w_en    (fifoWEn),
    .fifo_data_in (fifoDataIn),
    .gnt_onehot   (gntOnehot),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [15:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t vb(input string name, input logic rst, input logic [3:0] valid,
                              input logic [3:0] last, input logic full, input logic [63:0] data,
                              input logic [3:0] eReady, input logic eWen, input logic [15:0] eData,
                              input logic [3:0] eGnt, input logic eBusy);
    vec_t v;
    v.name = name; v.rst = rst; v.valid = valid; v.last = last; v.full = full; v.data = data;
    v.eReady = eReady; v.eWen = eWen; v.eData = eData; v.eGnt = eGnt; v.eBusy = eBusy;
    return v;
  endfunction

  function automatic vec_t idle(input string name, input logic rst, input logic [3:0] valid,
                                input logic [3:0] last, input logic full, input logic [63:0] data);
    return vb(name, rst, valid, last, full, data, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
  endfunction

  task automatic pushZeros();
    exp_t e;
    e.ready = '0; e.wen = 1'b0; e.data = '0; e.gnt = '0; e.busy = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (v.rst) begin
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
    end
    reqValid = v.valid;
    reqLast  = v.last;
    fifoFull = v.full;
    reqData  = v.data;
    e.ready = v.eReady; e.wen = v.eWen; e.data = v.eData; e.gnt = v.eGnt; e.busy = v.eBusy;
    expQ.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s %s got=%h want=%h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard empty got=none want=entry", tag);
      return;
    end
    e = expQ.pop_front();
    cmp(tag, "ready", {12'h000, reqReady}, {12'h000, e.ready});
    cmp(tag, "w_en",  {15'h0000, fifoWEn}, {15'h0000, e.wen});
    cmp(tag, "data",  fifoDataIn, e.data);
    cmp(tag, "gnt",   {12'h000, gntOnehot}, {12'h000, e.gnt});
    cmp(tag, "busy",  {15'h0000, busy}, {15'h0000, e.busy});
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #4;
    checkOutput(v.name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d3;
    rstn = 1'b0; reqValid = '0; reqLast = '0; reqData = '0; fifoFull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushZeros();
    checkOutput("reset state");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single burst from req1, then four-way rotation, then forced release with MAX_BURST=4.
    vecs.push_back(idle("T2 c0", 1'b1, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h00AA, 0, 0)));
    vecs.push_back(vb("T2 c1", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h00AA, 0, 0), 4'b0010, 1'b1, 16'h00AA, 4'b0010, 1'b1));
    vecs.push_back(vb("T2 c2", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h00BB, 0, 0), 4'b0010, 1'b1, 16'h00BB, 4'b0010, 1'b1));
    vecs.push_back(vb("T2 c3", 1'b0, 4'b0010, 4'b0010, 1'b0, mk(0, 16'h00CC, 0, 0), 4'b0010, 1'b1, 16'h00CC, 4'b0010, 1'b1));
    vecs.push_back(idle("T2 c4", 1'b0, 4'b0000, 4'b0000, 1'b0, mk(0, 0, 0, 0)));
    d3 = mk(16'h3000, 16'h3001, 16'h3002, 16'h3003);
    vecs.push_back(idle("T3 c0", 1'b1, 4'b1111, 4'b1111, 1'b0, d3));
    vecs.push_back(vb("T3 c1", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b0001, 1'b1, 16'h3000, 4'b0001, 1'b1));
    vecs.push_back(idle("T3 c2", 1'b0, 4'b1111, 4'b1111, 1'b0, d3));
    vecs.push_back(vb("T3 c3", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b0010, 1'b1, 16'h3001, 4'b0010, 1'b1));
    vecs.push_back(idle("T3 c4", 1'b0, 4'b1111, 4'b1111, 1'b0, d3));
    vecs.push_back(vb("T3 c5", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b0100, 1'b1, 16'h3002, 4'b0100, 1'b1));
    vecs.push_back(idle("T3 c6", 1'b0, 4'b1111, 4'b1111, 1'b0, d3));
    vecs.push_back(vb("T3 c7", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b1000, 1'b1, 16'h3003, 4'b1000, 1'b1));
    vecs.push_back(idle("T3 c8", 1'b0, 4'b1111, 4'b1111, 1'b0, d3));
    vecs.push_back(vb("T3 c9", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b0001, 1'b1, 16'h3000, 4'b0001, 1'b1));
    vecs.push_back(idle("T4 c0", 1'b0, 4'b0101, 4'b0001, 1'b0, mk(16'h1000, 0, 16'h2000, 0)));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(vb($sformatf("T4 beat%0d", k), 1'b0, 4'b0101, 4'b0001, 1'b0,
                        mk(16'h1000, 0, 16'h2000 + 16'(k), 0), 4'b0100, 1'b1, 16'h2000 + 16'(k), 4'b0100, 1'b1));
    end
    vecs.push_back(idle("T4 release", 1'b0, 4'b0101, 4'b0001, 1'b0, mk(16'h1000, 0, 16'h2004, 0)));
    vecs.push_back(vb("T4 req0", 1'b0, 4'b0101, 4'b0001, 1'b0, mk(16'h1000, 0, 16'h2004, 0), 4'b0001, 1'b1, 16'h1000, 4'b0001, 1'b1));
    vecs.push_back(idle("T4 idle2", 1'b0, 4'b0101, 4'b0001, 1'b0, mk(16'h1000, 0, 16'h2004, 0)));
    vecs.push_back(vb("T4 regrant", 1'b0, 4'b0101, 4'b0001, 1'b0, mk(16'h1000, 0, 16'h2004, 0), 4'b0100, 1'b1, 16'h2004, 4'b0100, 1'b1));

    foreach (vecs[i]) runVec(vecs[i]);

    // Backpressure on beat 2: nothing moves while full, and the beat count must not advance.
    runVec(idle("T5 c0", 1'b1, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h5001, 0, 0)));
    runVec(vb("T5 beat1", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h5001, 0, 0), 4'b0010, 1'b1, 16'h5001, 4'b0010, 1'b1));
    for (int k = 0; k < 3; k++) begin
      runVec(vb($sformatf("T5 full%0d", k), 1'b0, 4'b0010, 4'b0000, 1'b1, mk(0, 16'h5002, 0, 0), 4'b0000, 1'b0, 16'h5002, 4'b0010, 1'b1));
    end
    runVec(vb("T5 beat2", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h5002, 0, 0), 4'b0010, 1'b1, 16'h5002, 4'b0010, 1'b1));
    runVec(vb("T5 beat3", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h5003, 0, 0), 4'b0010, 1'b1, 16'h5003, 4'b0010, 1'b1));
    runVec(vb("T5 beat4", 1'b0, 4'b0010, 4'b0000, 1'b0, mk(0, 16'h5004, 0, 0), 4'b0010, 1'b1, 16'h5004, 4'b0010, 1'b1));
    runVec(idle("T5 after", 1'b0, 4'b0000, 4'b0000, 1'b0, mk(0, 0, 0, 0)));

    // Full already high when req3 wins; req0 requesting meanwhile must not steal the port.
    runVec(idle("T6 c0", 1'b1, 4'b1000, 4'b0000, 1'b1, mk(16'h6100, 0, 0, 16'h6000)));
    runVec(vb("T6 full0", 1'b0, 4'b1000, 4'b0000, 1'b1, mk(16'h6100, 0, 0, 16'h6000), 4'b0000, 1'b0, 16'h6000, 4'b1000, 1'b1));
    runVec(vb("T6 full1", 1'b0, 4'b1001, 4'b0000, 1'b1, mk(16'h6100, 0, 0, 16'h6000), 4'b0000, 1'b0, 16'h6000, 4'b1000, 1'b1));
    runVec(vb("T6 full2", 1'b0, 4'b1001, 4'b0000, 1'b1, mk(16'h6100, 0, 0, 16'h6000), 4'b0000, 1'b0, 16'h6000, 4'b1000, 1'b1));
    runVec(vb("T6 drain", 1'b0, 4'b1001, 4'b1001, 1'b0, mk(16'h6100, 0, 0, 16'h6000), 4'b1000, 1'b1, 16'h6000, 4'b1000, 1'b1));
    runVec(idle("T6 idle", 1'b0, 4'b0001, 4'b0001, 1'b0, mk(16'h6100, 0, 0, 0)));
    runVec(vb("T6 req0", 1'b0, 4'b0001, 4'b0001, 1'b0, mk(16'h6100, 0, 0, 0), 4'b0001, 1'b1, 16'h6100, 4'b0001, 1'b1));
    runVec(idle("T6 end", 1'b0, 4'b0000, 4'b0000, 1'b0, mk(0, 0, 0, 0)));

    // Asynchronous reset in the middle of req2's burst, after req1 moved the priority pointer.
    runVec(idle("T1 c0", 1'b1, 4'b0010, 4'b0010, 1'b0, mk(0, 16'h1111, 16'h2222, 0)));
    runVec(vb("T1 req1", 1'b0, 4'b0010, 4'b0010, 1'b0, mk(0, 16'h1111, 16'h2222, 0), 4'b0010, 1'b1, 16'h1111, 4'b0010, 1'b1));
    runVec(idle("T1 idle", 1'b0, 4'b0100, 4'b0000, 1'b0, mk(0, 16'h1111, 16'h2222, 0)));
    applyStimulus(vb("T1 req2", 1'b0, 4'b0100, 4'b0000, 1'b0, mk(0, 16'h1111, 16'h2222, 0), 4'b0100, 1'b1, 16'h2222, 4'b0100, 1'b1));
    #4;
    checkOutput("T1 req2");
    rstn = 1'b0;
    reqValid = '0; reqLast = '0; reqData = '0;
    #1;
    pushZeros();
    checkOutput("T1 async");
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    runVec(idle("T1 rearb", 1'b0, 4'b1111, 4'b1111, 1'b0, d3));
    runVec(vb("T1 prio0", 1'b0, 4'b1111, 4'b1111, 1'b0, d3, 4'b0001, 1'b1, 16'h3000, 4'b0001, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
